// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    // Drain FSM: wait for data, offer a byte, wait for the transmitter to finish.
    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitDone
    } drain_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: DEPTH x UART_DATA_W, one synchronous write port, asynchronous read port.
// The array is deliberately not reset; occupancy is tracked by the owner's pointers.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [AW-1:0]          waddr_i,
    input  logic [UART_DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]          raddr_i,
    output logic [UART_DATA_W-1:0] rdata_o
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];

    // Write the accepted byte into its slot.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART transmitter: queues host bytes and launches them one at a
// time through a wr_en/tx_busy handshake.
// Optional feature: define UART_TXF_OVF_EN to add the sticky overflow output.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                   txclk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   wr_valid,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            level,
    output logic [UART_DATA_W-1:0] din,
    output logic                   wr_en,
`ifdef UART_TXF_OVF_EN
    output logic                   overflow,
`endif
    input  logic                   tx_busy
);

    localparam logic [AW:0] LevelFull = (AW + 1)'(DEPTH);

    drain_state_e           state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            level_q, level_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic [UART_DATA_W-1:0] din_q, din_d;
    logic [UART_DATA_W-1:0] rdata;
    logic                   low_q, low_d;
    logic                   push, pop, load;

    assign push = wr_valid & ~full_q;
    // A pop happens on the edge where the transmitter acknowledges the offered byte.
    assign pop  = (state_q == StLoad) & tx_busy;
    assign load = (state_q == StIdle) & ~empty_q & ~tx_busy;

    uart_fifo_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk_i  (txclk),
        .we_i   (push),
        .waddr_i(wr_ptr_q),
        .wdata_i(wr_data),
        .raddr_i(rd_ptr_q),
        .rdata_o(rdata)
    );

    // Drain FSM state register.
    always_ff @(posedge txclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            low_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
        end
    end

    // Drain FSM next state; low_q remembers one idle sample so a single-cycle dip is ignored.
    always_comb begin
        state_d = state_q;
        low_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty_q && !tx_busy) state_d = StLoad;
            end
            StLoad: begin
                if (tx_busy) state_d = StWaitDone;
            end
            StWaitDone: begin
                low_d = ~tx_busy;
                if (!tx_busy && low_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Drain FSM outputs: launch request only while a byte is being offered.
    always_comb begin
        wr_en = (state_q == StLoad);
    end

    // Pointer, occupancy and held-byte next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        din_d    = din_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // Capture on entry to LOAD so later pushes or the pop cannot disturb the in-flight byte.
        if (load) din_d = rdata;
        full_d  = (level_d == LevelFull);
        empty_d = (level_d == '0);
    end

    // Pointer, occupancy and held-byte registers.
    always_ff @(posedge txclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            din_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            din_q    <= din_d;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;
    assign din   = din_q;

`ifdef UART_TXF_OVF_EN
    logic ovf_q, ovf_d;

    assign ovf_d = ovf_q | (wr_valid & full_q);

    // Sticky record of any refused push; only reset clears it.
    always_ff @(posedge txclk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed vector table, directed corner sequences, and a randomized
// run against a queue-based reference model with an in-order launch scoreboard.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       txclk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic [7:0] din;
    logic       wr_en;
    logic       tx_busy;
`ifdef UART_TXF_OVF_EN
    logic       overflow;
`endif

    always #5 txclk = ~txclk;

    uart_tx_fifo #(
        .DEPTH(DEPTH)
    ) dut (
        .txclk   (txclk),
        .rst_n   (rst_n),
        .wr_data (wr_data),
        .wr_valid(wr_valid),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .din     (din),
        .wr_en   (wr_en),
`ifdef UART_TXF_OVF_EN
        .overflow(overflow),
`endif
        .tx_busy (tx_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue; the drain process is tracked as
    // 0 = waiting for data, 1 = byte offered, 2 = transmitter running (with a count of idle samples).
    logic [7:0] mq[$];
    logic [7:0] exp_stream[$];
    logic [7:0] got_stream[$];
    int         m_phase;
    int         m_lows;
    logic [7:0] m_din;
    bit         m_ovf;

    function automatic void model_reset();
        mq.delete();
        m_phase = 0;
        m_lows  = 0;
        m_din   = 8'h00;
        m_ovf   = 1'b0;
    endfunction

    function automatic void model_step(input bit wv, input logic [7:0] wd, input bit busy);
        bit acc;
        acc = wv && (mq.size() < DEPTH);
        if (wv && !acc) m_ovf = 1'b1;
        case (m_phase)
            0: if (mq.size() > 0 && !busy) begin
                m_phase = 1;
                m_din   = mq[0];
            end
            1: if (busy) begin
                m_phase = 2;
                m_lows  = 0;
                void'(mq.pop_front());
            end
            default: begin
                if (busy) m_lows = 0;
                else if (m_lows >= 1) m_phase = 0;
                else m_lows = 1;
            end
        endcase
        if (acc) begin
            mq.push_back(wd);
            exp_stream.push_back(wd);
        end
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_level"}, 32'(level), mq.size());
        chk({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, "_full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, "_wr_en"}, 32'(wr_en), 32'(m_phase == 1));
        chk({tag, "_din"}, 32'(din), 32'(m_din));
`ifdef UART_TXF_OVF_EN
        chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
`endif
    endtask

    task automatic cycle();
        @(posedge txclk);
        @(negedge txclk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        tx_busy  = 1'b0;
        repeat (2) @(negedge txclk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit         wv;
        logic [7:0] wd;
        bit         busy;
        int         e_level;
        bit         e_empty;
        bit         e_wren;
        logic [7:0] e_din;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int         cnt;
        bit         hi;
        logic [7:0] seen[$];
        logic [7:0] exp35[3];

        // Cycle-by-cycle vectors from reset: launch latency, pop, push during WAIT_DONE,
        // single-cycle busy flicker, two-low return to idle, foreign busy blocking a load.
        vecs[0]  = '{1'b1, 8'h63, 1'b0, 1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b1, 8'h63};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b1, 8'h63};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h63};
        vecs[4]  = '{1'b1, 8'hA5, 1'b1, 1, 1'b0, 1'b0, 8'h63};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h63};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'h63};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h63};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h63};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b1, 8'hA5};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'hA5};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 8'hA5};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 8'hA5};
        vecs[13] = '{1'b1, 8'h3C, 1'b1, 1, 1'b0, 1'b0, 8'hA5};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'hA5};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b1, 8'h3C};

        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        tx_busy  = 1'b0;
        repeat (2) @(negedge txclk);
        chk("reset_level", 32'(level), 0);
        chk("reset_empty", 32'(empty), 1);
        chk("reset_full", 32'(full), 0);
        chk("reset_wr_en", 32'(wr_en), 0);
        chk("reset_din", 32'(din), 0);
`ifdef UART_TXF_OVF_EN
        chk("reset_overflow", 32'(overflow), 0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            wr_valid = vecs[i].wv;
            wr_data  = vecs[i].wd;
            tx_busy  = vecs[i].busy;
            cycle();
            chk($sformatf("vec%0d_level", i), 32'(level), vecs[i].e_level);
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
            chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].e_wren));
            chk($sformatf("vec%0d_din", i), 32'(din), 32'(vecs[i].e_din));
        end

        // Fill past capacity with the transmitter busy: 17th byte is dropped.
        do_reset();
        tx_busy = 1'b1;
        for (int k = 0; k < 17; k++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(k + 1);
            cycle();
            if (k == 14) chk("fill15_full", 32'(full), 0);
            if (k == 15) chk("fill16_full", 32'(full), 1);
        end
        wr_valid = 1'b0;
        chk("overfill_level", 32'(level), 16);
        chk("overfill_full", 32'(full), 1);
        chk("overfill_empty", 32'(empty), 0);
        chk("overfill_wr_en_blocked", 32'(wr_en), 0);
`ifdef UART_TXF_OVF_EN
        chk("overfill_overflow", 32'(overflow), 1);
        cycle();
        chk("overflow_sticky", 32'(overflow), 1);
`endif

        // Asynchronous reset while a byte is offered with 5 queued.
        do_reset();
`ifdef UART_TXF_OVF_EN
        chk("overflow_cleared", 32'(overflow), 0);
`endif
        tx_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h10 + k);
            cycle();
        end
        wr_valid = 1'b0;
        tx_busy  = 1'b0;
        cycle();
        chk("preload_wr_en", 32'(wr_en), 1);
        chk("preload_din", 32'(din), 32'h10);
        chk("preload_level", 32'(level), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_wr_en", 32'(wr_en), 0);
        chk("async_rst_level", 32'(level), 0);
        chk("async_rst_empty", 32'(empty), 1);
        chk("async_rst_full", 32'(full), 0);
        chk("async_rst_din", 32'(din), 0);
        @(negedge txclk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk($sformatf("post_rst%0d_wr_en", k), 32'(wr_en), 0);
            chk($sformatf("post_rst%0d_empty", k), 32'(empty), 1);
        end

        // Simultaneous push and pop at level 3.
        do_reset();
        tx_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'hA1 + k);
            cycle();
        end
        wr_valid = 1'b0;
        tx_busy  = 1'b0;
        cycle();
        chk("pp_load_wr_en", 32'(wr_en), 1);
        chk("pp_load_din", 32'(din), 32'hA1);
        wr_valid = 1'b1;
        wr_data  = 8'hA4;
        tx_busy  = 1'b1;
        cycle();
        wr_valid = 1'b0;
        chk("pp_level", 32'(level), 3);
        chk("pp_wr_en", 32'(wr_en), 0);
        chk("pp_din_held", 32'(din), 32'hA1);

        // Three back-to-back pushes drained by a transmitter busy for 20 cycles per byte.
        do_reset();
        exp35 = '{8'hF0, 8'hCC, 8'h63};
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1;
            wr_data  = exp35[k];
            cycle();
        end
        wr_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (cnt > 0) begin
                cnt--;
                tx_busy = (cnt > 0);
            end else if (wr_en) begin
                seen.push_back(din);
                tx_busy = 1'b1;
                cnt     = 20;
            end
            cycle();
        end
        chk("tx3_launches", seen.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < seen.size()) chk($sformatf("tx3_byte%0d", k), 32'(seen[k]), 32'(exp35[k]));
        end
        chk("tx3_drained", 32'(empty), 1);

        // Randomized traffic against the reference model.
        do_reset();
        exp_stream.delete();
        got_stream.delete();
        hi = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check_model("rnd");
            if (cyc % 200 == 0) hi = 1'($urandom_range(0, 1));
            wr_valid = hi ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            wr_data  = 8'($urandom);
            if ($urandom_range(0, 2) == 0) tx_busy = ~tx_busy;
            if (wr_en && tx_busy) got_stream.push_back(din);
            model_step(wr_valid, wr_data, tx_busy);
            cycle();
        end
        check_model("rnd_end");
        chk("rnd_launch_count", got_stream.size(), exp_stream.size() - mq.size());
        chk("rnd_wrap_exercised", 32'(got_stream.size() >= 40), 1);
        for (int i = 0; i < got_stream.size(); i++) begin
            if (i < exp_stream.size()) begin
                chk($sformatf("rnd_order%0d", i), 32'(got_stream[i]), 32'(exp_stream[i]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
